// File: rtl/prog_loader.sv
// prog_loader
//
// Fills instruction memory from an external byte stream before the core runs.
// A frame is: CNT_LO, CNT_HI (16-bit word count N), 4*N data bytes, then one
// checksum byte. The checksum is the XOR of the data bytes only.
//
// Data bytes are assembled little-endian into 32-bit words. Each word is
// written to consecutive word addresses starting at BASE_ADDR through the
// memory's write port. The core is held in reset until a load finishes with a
// good checksum.
//
// Parameters:
//   BASE_ADDR  byte address of the first word written; must be word-aligned
//   MAX_WORDS  largest word count accepted; larger counts end in ERR
//
// Ports:
//   CLK         clock; all state changes on the rising edge
//   RESET       synchronous active-high reset
//   START       begins a load; only honoured in IDLE, DONE or ERR
//   BYTE_IN     stream byte
//   BYTE_VALID  BYTE_IN is valid
//   BYTE_READY  loader accepts a byte this cycle (Moore, from state only)
//   MEM_WE2     one-cycle write strobe to instruction memory
//   MEM_ADDR2   word-aligned byte address of the write
//   MEM_DIN2    instruction word written
//   CPU_RESET   holds the core in reset (low only in DONE)
//   BUSY        a load is in progress
//   DONE        last load completed with a good checksum
//   ERR         last load failed (bad checksum or oversize count)
module prog_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  output logic        MEM_WE2,
  output logic [31:0] MEM_ADDR2,
  output logic [31:0] MEM_DIN2,
  output logic        CPU_RESET,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cntLo_q, cntLo_d;
  logic [15:0] wordCnt_q, wordCnt_d;
  logic [15:0] wordIdx_q, wordIdx_d;
  logic [1:0]  byteIdx_q, byteIdx_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wrAddr_q, wrAddr_d;
  logic [31:0] wrData_q, wrData_d;
  logic        byteReady_q, busy_q, cpuReset_q, done_q, err_q;
  logic        accept;
  logic [15:0] hdrCnt;

  // Handshake uses the registered ready, so BYTE_VALID never reaches an output.
  assign accept = byteReady_q & BYTE_VALID;
  assign hdrCnt = {BYTE_IN, cntLo_q};

  // Next-state logic. Assembly (asm) and write (wrData) registers are separate
  // so byte 0 of the next word can be taken while the previous word is written.
  always_comb begin
    state_d   = state_q;
    cntLo_d   = cntLo_q;
    wordCnt_d = wordCnt_q;
    wordIdx_d = wordIdx_q;
    byteIdx_d = byteIdx_q;
    chk_d     = chk_q;
    asm_d     = asm_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    wrAddr_d  = wrAddr_q;
    wrData_d  = wrData_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (START) begin
          state_d   = S_HDR0;
          wordIdx_d = '0;
          byteIdx_d = '0;
          chk_d     = '0;
          addr_d    = BASE_ADDR;
        end
      end
      S_HDR0: begin
        if (accept) begin
          cntLo_d = BYTE_IN;
          state_d = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          wordCnt_d = hdrCnt;
          if (hdrCnt == 16'd0)
            state_d = S_CHK;
          else if ({16'd0, hdrCnt} > 32'(MAX_WORDS))
            state_d = S_ERR;
          else
            state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d     = chk_q ^ BYTE_IN;
          byteIdx_d = byteIdx_q + 2'd1;
          case (byteIdx_q)
            2'd0: asm_d[7:0]   = BYTE_IN;
            2'd1: asm_d[15:8]  = BYTE_IN;
            2'd2: asm_d[23:16] = BYTE_IN;
            default: begin
              // Fourth byte completes the word; it goes straight into the
              // write register rather than through the assembly register.
              we_d      = 1'b1;
              wrAddr_d  = addr_q;
              wrData_d  = {BYTE_IN, asm_q[23:0]};
              addr_d    = addr_q + 32'd4;
              wordIdx_d = wordIdx_q + 16'd1;
              if (wordIdx_q == wordCnt_q - 16'd1)
                state_d = S_CHK;
            end
          endcase
        end
      end
      S_CHK: begin
        if (accept)
          state_d = (BYTE_IN == chk_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. Status outputs are decoded from the next
  // state so they change on the same edge as the state itself.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cntLo_q     <= '0;
      wordCnt_q   <= '0;
      wordIdx_q   <= '0;
      byteIdx_q   <= '0;
      chk_q       <= '0;
      asm_q       <= '0;
      addr_q      <= BASE_ADDR;
      we_q        <= 1'b0;
      wrAddr_q    <= BASE_ADDR;
      wrData_q    <= '0;
      byteReady_q <= 1'b0;
      busy_q      <= 1'b0;
      cpuReset_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cntLo_q     <= cntLo_d;
      wordCnt_q   <= wordCnt_d;
      wordIdx_q   <= wordIdx_d;
      byteIdx_q   <= byteIdx_d;
      chk_q       <= chk_d;
      asm_q       <= asm_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wrAddr_q    <= wrAddr_d;
      wrData_q    <= wrData_d;
      byteReady_q <= (state_d == S_HDR0) || (state_d == S_HDR1) ||
                     (state_d == S_DATA) || (state_d == S_CHK);
      busy_q      <= (state_d == S_HDR0) || (state_d == S_HDR1) ||
                     (state_d == S_DATA) || (state_d == S_CHK);
      cpuReset_q  <= (state_d != S_DONE);
      done_q      <= (state_d == S_DONE);
      err_q       <= (state_d == S_ERR);
    end
  end

  assign BYTE_READY = byteReady_q;
  assign MEM_WE2    = we_q;
  assign MEM_ADDR2  = wrAddr_q;
  assign MEM_DIN2   = wrData_q;
  assign CPU_RESET  = cpuReset_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;

endmodule
